apb_mux_n: RTL and testbench
============================

Name: apb_mux_n

Overview:
- Parametrised N-slave APB response/select multiplexer with address decode, a per-transfer state machine and a slave watchdog.
- Sits between one APB master (bridge) and NUM_SLAVES APB slaves.
- Decodes PADDR into a one-hot slave select and holds that selection for the whole transfer.
- Routes the selected slave's PRDATA/PREADY/PSLVERR back to the master. Errors out unmapped addresses and hung slaves.

Parameters:
- DATAWIDTH, 32, PRDATA width per slave.
- ADDRWIDTH, 32, PADDR width.
- NUM_SLAVES, 4, number of slave ports (2..16).
- REGION_LSB, 12, LSB of the slave-index field in PADDR.
- TIMEOUT_CYCLES, 16, access-phase cycles without PREADY before abort (≥2; used only with watchdog).

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous active-high reset.
- PADDR  in  ADDRWIDTH  master address.
- PSEL  in  1  master select.
- PENABLE  in  1  master enable.
- PSELout  out  NUM_SLAVES  one-hot slave selects.
- PREADYin  in  NUM_SLAVES  per-slave ready.
- PSLVERRin  in  NUM_SLAVES  per-slave error.
- PRDATAin  in  NUM_SLAVES*DATAWIDTH  packed slave read data; slave k occupies bits [k*DATAWIDTH +: DATAWIDTH].
- PRDATA  out  DATAWIDTH  read data to master.
- PREADY  out  1  ready to master.
- PSLVERR  out  1  error to master.
- TIMEOUT_PULSE  out  1  one-cycle registered pulse on a watchdog abort.

Behaviour:
- IDX_W = max(1, $clog2(NUM_SLAVES)). The decode index is PADDR[REGION_LSB +: IDX_W]. An index ≥ NUM_SLAVES is unmapped.
- States: IDLE, ACCESS, ABORT.
- Reset (PRESET=1 at a PCLK edge):
  - State goes to IDLE; idx_q=0, mapped_q=0, counter=0, TIMEOUT_PULSE=0.
  - All outputs are 0 while in IDLE with PSEL=0.
- IDLE:
  - PSELout = onehot(decode index) when PSEL=1 and the address is mapped, else 0. Setup-phase select is combinational, so slaves see PSEL in the setup cycle.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - On PSEL=1 && PENABLE=0: latch idx_q and mapped_q, clear the counter, go to ACCESS.
- ACCESS:
  - PSELout = onehot(idx_q) if mapped_q, else 0. The index is frozen; later PADDR changes are ignored.
  - Mapped slave: PREADY = PREADYin[idx_q] & PENABLE. PSLVERR = PSLVERRin[idx_q] & PREADY. PRDATA = slave k data when PREADY, else 0.
  - Unmapped: PREADY=PENABLE, PSLVERR=PENABLE, PRDATA=0. This completes in 1 access cycle.
  - PREADY=1: transfer done, go to IDLE. A back-to-back setup in the next cycle is handled by IDLE with zero bubble.
  - PSEL drops mid-access (protocol violation): go to IDLE immediately, no response.
  - Counter increments on each ACCESS cycle with PENABLE=1 && PREADY=0, saturating. Watchdog enabled and counter reaches TIMEOUT_CYCLES-1 with PREADY still 0: go to ABORT.
- ABORT:
  - Lasts exactly one cycle.
  - PSELout=0, PREADY=1, PSLVERR=1, PRDATA=0.
  - TIMEOUT_PULSE is registered high during the ABORT cycle.
  - Next state is IDLE.
- Simultaneous events:
  - Slave PREADY in the same cycle the counter hits its limit: the slave response wins and ABORT is not entered.
  - PRESET has priority over everything; reset mid-transfer drops PSELout and PREADY in the next cycle.
- The master sees a deterministic response for every transfer: slave data, a decode error or a timeout error.

Optional Feature:
- Macro: APB_MUX_WATCHDOG_EN.
- Defined: counter, ABORT state and TIMEOUT_PULSE are active as described above.
- Undefined:
  - Counter and ABORT logic are not compiled, and TIMEOUT_PULSE is tied 0.
  - ACCESS waits indefinitely for PREADYin[idx_q].
  - Decode errors still apply.

Decomposition:
- Shared package apb_pkg holds:
  - state enum (IDLE=2'd0, ACCESS=2'd1, ABORT=2'd2);
  - an idx_width function (clog2, min 1);
  - APB_DATA_ZERO constant.
- One natural sub-module, apb_addr_decode. It is combinational and takes PADDR, REGION_LSB and NUM_SLAVES. It outputs index, mapped and the one-hot select. The top block owns the FSM, counter and response mux.

Test Plan:
- Defaults; read PADDR=0x0000_2000 (slave 2), PREADYin[2] high on the 2nd access cycle, PRDATAin slave2=0xA5A5_0002. Expect PSELout=4'b0100 from setup through completion; PRDATA=0xA5A5_0002, PREADY=1, PSLVERR=0 on the completion cycle only.
- NUM_SLAVES=3, PADDR=0x0000_3000 (unmapped). Expect PSELout=0; first access cycle gives PREADY=1, PSLVERR=1, PRDATA=0.
- Watchdog enabled, slave 1 never ready, TIMEOUT_CYCLES=16. Expect ABORT after 15 stalled access cycles: PREADY=1, PSLVERR=1, PSELout=0, TIMEOUT_PULSE=1 for exactly one cycle. Repeat with the macro undefined: no completion after 100 cycles.
- Back-to-back: slave 0, then slave 3 in the cycle immediately after completion. Expect PSELout 4'b0001 → 4'b1000 with no idle cycle; PADDR change during the slave-0 access does not move the select.
- PRESET asserted during ACCESS with PREADYin low. Next cycle: PSELout=0, PREADY=0, TIMEOUT_PULSE=0; a new transfer afterwards completes normally. Also cover PREADYin[idx] in the same cycle as the timeout limit: slave data returned, no abort.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and helpers for the APB slave mux.
// Holds the transfer state encoding and index-width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ABORT  = 2'd2
  } state_e;

  // Replicated to DATAWIDTH wherever a zero response is driven.
  localparam logic APB_DATA_ZERO = 1'b0;

  // Width of the slave-index field; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: PADDR region field to slave index and one-hot select.
// Indices at or above NUM_SLAVES are reported as unmapped.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDRWIDTH  = 32,
  parameter int NUM_SLAVES = 4,
  parameter int REGION_LSB = 12,
  parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDRWIDTH-1:0]  paddr_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  mapped_o,
  output logic [NUM_SLAVES-1:0] sel_o
);

  // Only the region field takes part in the decode.
  logic unused_paddr;
  assign unused_paddr = ^paddr_i;

  assign idx_o    = paddr_i[REGION_LSB +: IDX_W];
  assign mapped_o = (32'(idx_o) < NUM_SLAVES);

  // One-hot select, empty for an unmapped region
  always_comb begin
    sel_o = '0;
    if (mapped_o) sel_o = NUM_SLAVES'(1) << idx_o;
  end

endmodule

// File: rtl/apb_mux_n.sv
// apb_mux_n: N-slave APB select/response mux with decode and watchdog.
// Define APB_MUX_WATCHDOG_EN to enable the access-phase timeout abort.
module apb_mux_n
  import apb_pkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int ADDRWIDTH      = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int REGION_LSB     = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [ADDRWIDTH-1:0]            PADDR,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  output logic [NUM_SLAVES-1:0]           PSELout,
  input  logic [NUM_SLAVES-1:0]           PREADYin,
  input  logic [NUM_SLAVES-1:0]           PSLVERRin,
  input  logic [NUM_SLAVES*DATAWIDTH-1:0] PRDATAin,
  output logic [DATAWIDTH-1:0]            PRDATA,
  output logic                            PREADY,
  output logic                            PSLVERR,
  output logic                            TIMEOUT_PULSE
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  if (NUM_SLAVES < 2 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("apb_mux_n: parameter out of range");
  end

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    mapped_q, mapped_d;
  logic [IDX_W-1:0]        dec_idx;
  logic                    dec_mapped;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    slv_rdy, slv_err;
  logic [DATAWIDTH-1:0]    slv_data;
  logic                    expire;

  apb_addr_decode #(
    .ADDRWIDTH  (ADDRWIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .REGION_LSB (REGION_LSB),
    .IDX_W      (IDX_W)
  ) u_dec (
    .paddr_i  (PADDR),
    .idx_o    (dec_idx),
    .mapped_o (dec_mapped),
    .sel_o    (dec_sel)
  );

  // Pick the latched slave's response lines
  always_comb begin
    slv_rdy  = 1'b0;
    slv_err  = 1'b0;
    slv_data = {DATAWIDTH{APB_DATA_ZERO}};
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (32'(idx_q) == k) begin
        slv_rdy  = PREADYin[k];
        slv_err  = PSLVERRin[k];
        slv_data = PRDATAin[k*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Master-facing select and response for the current state
  always_comb begin
    PSELout = '0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = {DATAWIDTH{APB_DATA_ZERO}};
    unique case (state_q)
      IDLE: begin
        if (PSEL) PSELout = dec_sel;
      end
      ACCESS: begin
        if (mapped_q) begin
          PSELout = NUM_SLAVES'(1) << idx_q;
          PREADY  = slv_rdy & PENABLE;
          PSLVERR = slv_err & slv_rdy & PENABLE;
          if (slv_rdy && PENABLE) PRDATA = slv_data;
        end else begin
          PREADY  = PENABLE;
          PSLVERR = PENABLE;
        end
      end
      ABORT: begin
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
      end
      default: ;
    endcase
  end

  // Transfer sequencing; a slave response beats the watchdog
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mapped_d = mapped_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          idx_d    = dec_idx;
          mapped_d = dec_mapped;
        end
      end
      ACCESS: begin
        if (!PSEL || PREADY) state_d = IDLE;
        else if (expire)     state_d = ABORT;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched decode registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      mapped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mapped_q <= mapped_d;
    end
  end

`ifdef APB_MUX_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tp_q;
  logic             stall;

  assign stall  = (state_q == ACCESS) && PENABLE && !PREADY;
  assign expire = stall && (cnt_d == CNT_LIM);

  // Saturating count of stalled access cycles, cleared between transfers
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = '0;
    else if (stall && cnt_q != CNT_LIM)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter and abort pulse, the pulse aligned with the abort cycle
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
      tp_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tp_q  <= (state_d == ABORT);
    end
  end

  assign TIMEOUT_PULSE = tp_q;
`else
  assign expire        = 1'b0;
  assign TIMEOUT_PULSE = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mux_n.sv
// tb_apb_mux_n: directed bench with a transfer-level reference model.
// Expectations for the watchdog follow APB_MUX_WATCHDOG_EN.
module tb_apb_mux_n;

  localparam int TO = 16;

  typedef struct packed {
    logic [3:0]  sel;
    logic        rdy;
    logic        err;
    logic [31:0] dat;
    logic        tp;
  } out_t;

  logic        clk = 1'b0;
  logic        preset;
  logic [31:0] paddr;
  logic        psel, penable;
  logic [3:0]  rdy_v [2];
  logic [3:0]  err_v [2];
  logic [127:0] dat_v [2];

  logic [3:0]  sel4;
  logic [2:0]  sel3;
  logic [31:0] dat4, dat3;
  logic        rdy4, rdy3, err4, err3, tp4, tp3;
  out_t        got [2];

  int checks   = 0;
  int failures = 0;
  bit live     = 0;

  bit m_act [2];
  bit m_abt [2];
  bit m_map [2];
  int m_idx [2];
  int m_stl [2];

  always #5 clk = ~clk;

  apb_mux_n #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(TO)) u4 (
    .PCLK(clk), .PRESET(preset), .PADDR(paddr),
    .PSEL(psel), .PENABLE(penable), .PSELout(sel4),
    .PREADYin(rdy_v[0]), .PSLVERRin(err_v[0]),
    .PRDATAin(dat_v[0]), .PRDATA(dat4), .PREADY(rdy4),
    .PSLVERR(err4), .TIMEOUT_PULSE(tp4)
  );

  apb_mux_n #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(TO)) u3 (
    .PCLK(clk), .PRESET(preset), .PADDR(paddr),
    .PSEL(psel), .PENABLE(penable), .PSELout(sel3),
    .PREADYin(rdy_v[1][2:0]), .PSLVERRin(err_v[1][2:0]),
    .PRDATAin(dat_v[1][95:0]), .PRDATA(dat3), .PREADY(rdy3),
    .PSLVERR(err3), .TIMEOUT_PULSE(tp3)
  );

  assign got[0] = {sel4, rdy4, err4, dat4, tp4};
  assign got[1] = {1'b0, sel3, rdy3, err3, dat3, tp3};

  function automatic int nsl(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  // What the master and slaves must see, from the transfer rules
  function automatic out_t model_out(input int d);
    out_t o;
    int   ai;
    o  = '0;
    ai = int'(paddr[13:12]);
    if (m_abt[d]) begin
      o.rdy = 1'b1;
      o.err = 1'b1;
      o.tp  = 1'b1;
    end else if (m_act[d]) begin
      if (m_map[d]) begin
        o.sel = 4'(1) << m_idx[d];
        o.rdy = rdy_v[d][m_idx[d]] & penable;
        o.err = err_v[d][m_idx[d]] & o.rdy;
        if (o.rdy) o.dat = dat_v[d][m_idx[d]*32 +: 32];
      end else begin
        o.rdy = penable;
        o.err = penable;
      end
    end else if (psel && ai < nsl(d)) begin
      o.sel = 4'(1) << ai;
    end
    return o;
  endfunction

  function automatic bit model_rdy(input int d);
    out_t o;
    o = model_out(d);
    return o.rdy;
  endfunction

  // Advance the per-transfer bookkeeping at each clock edge
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (preset) begin
        m_act[d] <= 0;
        m_abt[d] <= 0;
      end else if (m_abt[d]) begin
        m_abt[d] <= 0;
      end else if (m_act[d]) begin
        if (!psel || model_rdy(d)) m_act[d] <= 0;
        else if (penable) begin
          m_stl[d] <= m_stl[d] + 1;
`ifdef APB_MUX_WATCHDOG_EN
          if (m_stl[d] + 1 == TO - 1) begin
            m_act[d] <= 0;
            m_abt[d] <= 1;
          end
`endif
        end
      end else if (psel && !penable) begin
        m_act[d] <= 1;
        m_idx[d] <= int'(paddr[13:12]);
        m_map[d] <= int'(paddr[13:12]) < nsl(d);
        m_stl[d] <= 0;
      end
    end
    if (preset) live <= 1;
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (live) begin
      for (int d = 0; d < 2; d++) begin
        out_t e;
        e = model_out(d);
        chk($sformatf("sel[%0d]", d), 32'(got[d].sel), 32'(e.sel));
        chk($sformatf("rdy[%0d]", d), 32'(got[d].rdy), 32'(e.rdy));
        chk($sformatf("err[%0d]", d), 32'(got[d].err), 32'(e.err));
        chk($sformatf("dat[%0d]", d), got[d].dat, e.dat);
        chk($sformatf("tp[%0d]", d), 32'(got[d].tp), 32'(e.tp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    psel     = 0;
    penable  = 0;
    rdy_v[0] = '0;
    rdy_v[1] = '0;
    err_v[0] = '0;
    err_v[1] = '0;
  endtask

  task automatic setup(input logic [31:0] a);
    psel    = 1;
    penable = 0;
    paddr   = a;
    tick();
    penable = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int hit;
    int cnt;
    preset = 1;
    paddr  = '0;
    idle_bus();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        dat_v[d][k*32 +: 32] = 32'hA5A5_0000 + 32'(k);
    tick();
    tick();
    @(negedge clk);
    chk("rst_sel", 32'(sel4), 0);
    chk("rst_rdy", 32'(rdy4), 0);
    chk("rst_tp", 32'(tp4), 0);
    @(posedge clk); #1;
    preset = 0;
    tick();

    // Read slave 2, ready on the second access cycle
    psel = 1; penable = 0; paddr = 32'h0000_2000;
    @(negedge clk);
    chk("t1_setup_sel", 32'(sel4), 32'h4);
    tick();
    penable = 1;
    @(negedge clk);
    chk("t1_wait_rdy", 32'(rdy4), 0);
    tick();
    rdy_v[0][2] = 1; rdy_v[1][2] = 1;
    @(negedge clk);
    chk("t1_sel", 32'(sel4), 32'h4);
    chk("t1_data", dat4, 32'hA5A5_0002);
    chk("t1_rdy", 32'(rdy4), 1);
    chk("t1_err", 32'(err4), 0);
    tick();
    idle_bus();
    tick();

    // Unmapped region on the three-slave instance
    rdy_v[0] = '1;
    setup(32'h0000_3000);
    @(negedge clk);
    chk("t2_sel", 32'(sel3), 0);
    chk("t2_rdy", 32'(rdy3), 1);
    chk("t2_err", 32'(err3), 1);
    chk("t2_data", dat3, 0);
    tick();
    idle_bus();
    tick();

    // Slave 1 never ready
    setup(32'h0000_1000);
`ifdef APB_MUX_WATCHDOG_EN
    hit = 0;
    for (int c = 1; c <= 40 && hit == 0; c++) begin
      @(negedge clk);
      if (rdy4) hit = c;
      else tick();
    end
    chk("t3_abort_cycle", 32'(hit), 32'd16);
    chk("t3_abort_sel", 32'(sel4), 0);
    chk("t3_abort_err", 32'(err4), 1);
    chk("t3_abort_tp", 32'(tp4), 1);
    tick();
    idle_bus();
    @(negedge clk);
    chk("t3_tp_one_cycle", 32'(tp4), 0);
`else
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rdy4) cnt++;
      tick();
    end
    chk("t3_no_completion", 32'(cnt), 0);
    idle_bus();
`endif
    tick();

    // Back-to-back: slave 0 then slave 3, address moved mid-access
    setup(32'h0000_0000);
    paddr = 32'h0000_3000;
    @(negedge clk);
    chk("t4_frozen_sel", 32'(sel4), 32'h1);
    tick();
    rdy_v[0][0] = 1; rdy_v[1][0] = 1;
    @(negedge clk);
    chk("t4_s0_data", dat4, 32'hA5A5_0000);
    tick();
    rdy_v[0] = '0; rdy_v[1] = '0;
    penable = 0;
    @(negedge clk);
    chk("t4_s3_setup_sel", 32'(sel4), 32'h8);
    tick();
    penable = 1;
    rdy_v[0][3] = 1;
    @(negedge clk);
    chk("t4_s3_data", dat4, 32'hA5A5_0003);
    tick();
    idle_bus();
    tick();

    // Reset during a stalled access
    setup(32'h0000_2000);
    tick();
    preset = 1;
    idle_bus();
    tick();
    @(negedge clk);
    chk("t5_sel", 32'(sel4), 0);
    chk("t5_rdy", 32'(rdy4), 0);
    chk("t5_tp", 32'(tp4), 0);
    @(posedge clk); #1;
    preset = 0;
    setup(32'h0000_2000);
    rdy_v[0][2] = 1; rdy_v[1][2] = 1;
    @(negedge clk);
    chk("t5_after_data", dat4, 32'hA5A5_0002);
    tick();
    idle_bus();
    tick();

    // Slave answers on the last cycle before the limit, with an error
    setup(32'h0000_1000);
    for (int c = 0; c < TO - 2; c++) tick();
    rdy_v[0][1] = 1; rdy_v[1][1] = 1;
    err_v[0][1] = 1; err_v[1][1] = 1;
    @(negedge clk);
    chk("t6_rdy", 32'(rdy4), 1);
    chk("t6_data", dat4, 32'hA5A5_0001);
    chk("t6_err", 32'(err4), 1);
    chk("t6_tp", 32'(tp4), 0);
    tick();
    idle_bus();
    @(negedge clk);
    chk("t6_no_abort_rdy", 32'(rdy4), 0);
    chk("t6_no_abort_tp", 32'(tp4), 0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
